// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, ALUOp codes, mux selects,
// multicycle controller state encoding and the control output bundle.
// MC_MAIN_CTRL_ADDI_EN adds the addi execute/writeback states.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RT      = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_JEX     = 4'd9
`ifdef MC_MAIN_CTRL_ADDI_EN
        ,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
`endif
    } mc_state_t;

    typedef struct packed {
        logic              pc_write;
        logic              branch;
        logic              iord;
        logic              mem_read;
        logic              mem_write;
        logic              ir_write;
        logic              reg_dst;
        logic              mem_to_reg;
        logic              reg_write;
        logic              alu_src_a;
        logic [SEL_W-1:0]  alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [SEL_W-1:0]  pc_src;
        logic              illegal;
    } mc_ctrl_t;

    // Opcodes this controller knows how to sequence.
    function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
`ifdef MC_MAIN_CTRL_ADDI_EN
            OP_ADDI: legal = 1'b1;
`else
            OP_ADDI: legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Opcode/handshake inputs and datapath control outputs of the main controller.
interface mc_main_ctrl_if;
    import mips_pkg::*;

    logic [OPCODE_W-1:0] iopcode;
    logic                iMemReady;
    logic                oPCWrite;
    logic                oBranch;
    logic                oIorD;
    logic                oMemRead;
    logic                oMemWrite;
    logic                oIRWrite;
    logic                oRegDst;
    logic                oMemtoReg;
    logic                oRegWrite;
    logic                oALUSrcA;
    logic [SEL_W-1:0]    oALUSrcB;
    logic [ALUOP_W-1:0]  oALUOp;
    logic [SEL_W-1:0]    oPCSrc;
    logic                oIllegal;

    modport master (
        output iopcode, iMemReady,
        input  oPCWrite, oBranch, oIorD, oMemRead, oMemWrite, oIRWrite,
               oRegDst, oMemtoReg, oRegWrite, oALUSrcA, oALUSrcB, oALUOp,
               oPCSrc, oIllegal
    );

    modport slave (
        input  iopcode, iMemReady,
        output oPCWrite, oBranch, oIorD, oMemRead, oMemWrite, oIRWrite,
               oRegDst, oMemtoReg, oRegWrite, oALUSrcA, oALUSrcB, oALUOp,
               oPCSrc, oIllegal
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of controller state (plus memory ready and the live
// opcode in DECODE) into the datapath control bundle. MC_MAIN_CTRL_ADDI_EN
// adds decode for the addi states.
module mc_ctrl_outdec
    import mips_pkg::*;
(
    input  logic                rst_n_i,
    input  mc_state_t           state_i,
    input  logic                mem_ready_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output mc_ctrl_t            ctrl_o
);

    // Per-state control values; everything not set stays 0, reset forces all 0.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.illegal   = !op_is_legal(opcode_i);
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.branch    = 1'b1;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
            end
            S_JEX: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
`ifdef MC_MAIN_CTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
        if (!rst_n_i) begin
            ctrl_o = '0;
        end
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback steps and stalls memory steps on iMemReady.
// MC_MAIN_CTRL_ADDI_EN makes opcode 001000 (addi) legal.
module mc_main_ctrl
    import mips_pkg::*;
(
    input  logic          iclk,
    input  logic          irst_n,
    mc_main_ctrl_if.slave bus
);

    mc_state_t           state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    mc_ctrl_t            ctrl;

    // State and latched-opcode registers, synchronous active-low reset.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q  <= S_FETCH;
            opcode_q <= OP_RTYPE;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state logic; opcode captured in DECODE so later steps ignore iopcode.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_FETCH: begin
                if (bus.iMemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = bus.iopcode;
                case (bus.iopcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_MAIN_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.iMemReady) state_d = S_MEMWB;
            end
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR: begin
                if (bus.iMemReady) state_d = S_FETCH;
            end
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
`ifdef MC_MAIN_CTRL_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .rst_n_i     (irst_n),
        .state_i     (state_q),
        .mem_ready_i (bus.iMemReady),
        .opcode_i    (bus.iopcode),
        .ctrl_o      (ctrl)
    );

    assign bus.oPCWrite  = ctrl.pc_write;
    assign bus.oBranch   = ctrl.branch;
    assign bus.oIorD     = ctrl.iord;
    assign bus.oMemRead  = ctrl.mem_read;
    assign bus.oMemWrite = ctrl.mem_write;
    assign bus.oIRWrite  = ctrl.ir_write;
    assign bus.oRegDst   = ctrl.reg_dst;
    assign bus.oMemtoReg = ctrl.mem_to_reg;
    assign bus.oRegWrite = ctrl.reg_write;
    assign bus.oALUSrcA  = ctrl.alu_src_a;
    assign bus.oALUSrcB  = ctrl.alu_src_b;
    assign bus.oALUOp    = ctrl.alu_op;
    assign bus.oPCSrc    = ctrl.pc_src;
    assign bus.oIllegal  = ctrl.illegal;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: per-cycle expected control vectors are
// queued as stimulus is driven and compared on the falling edge.
module tb_mc_main_ctrl;

    // Expected vector layout:
    // {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
    //  RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], Illegal}
    localparam logic [16:0] E_ZERO       = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_FETCH_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] E_DEC_ILL    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] E_MEMADR     = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_MEMRD      = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MEMWB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] E_MEMWR      = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_RTEX       = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] E_RTWB       = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] E_BEQ        = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] E_JEX        = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
`ifdef MC_MAIN_CTRL_ADDI_EN
    localparam logic [16:0] E_ADDIWB     = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
`endif

    localparam logic [5:0] C_R    = 6'b000000;
    localparam logic [5:0] C_LW   = 6'b100011;
    localparam logic [5:0] C_SW   = 6'b101011;
    localparam logic [5:0] C_BEQ  = 6'b000100;
    localparam logic [5:0] C_J    = 6'b000010;
    localparam logic [5:0] C_ADDI = 6'b001000;
    localparam logic [5:0] C_BAD  = 6'b111111;

    typedef struct packed {
        logic        rst_n;
        logic        mr;
        logic [5:0]  op;
        logic        rnd;
        logic [16:0] exp;
    } cyc_t;

    logic iclk;
    logic irst_n;
    int   checks;
    int   errors;
    logic [16:0] exp_q[$];

    mc_main_ctrl_if bus_if ();

    mc_main_ctrl dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .bus    (bus_if.slave)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    function automatic cyc_t mk(input logic rst_n, input logic mr, input logic [5:0] op,
                                input logic rnd, input logic [16:0] exp);
        cyc_t c;
        c.rst_n = rst_n;
        c.mr    = mr;
        c.op    = op;
        c.rnd   = rnd;
        c.exp   = exp;
        return c;
    endfunction

    function automatic logic [16:0] outs();
        return {bus_if.oPCWrite, bus_if.oBranch, bus_if.oIorD, bus_if.oMemRead,
                bus_if.oMemWrite, bus_if.oIRWrite, bus_if.oRegDst, bus_if.oMemtoReg,
                bus_if.oRegWrite, bus_if.oALUSrcA, bus_if.oALUSrcB, bus_if.oALUOp,
                bus_if.oPCSrc, bus_if.oIllegal};
    endfunction

    // Apply one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic drive(input cyc_t c);
        @(posedge iclk);
        #1;
        irst_n           = c.rst_n;
        bus_if.iMemReady = c.mr;
        bus_if.iopcode   = c.rnd ? 6'($urandom) : c.op;
        exp_q.push_back(c.exp);
    endtask

    task automatic test_reset();
        cyc_t s[$];
        logic [16:0] got, e;
        s.push_back(mk(1'b0, 1'b1, C_LW, 1'b0, E_ZERO));
        s.push_back(mk(1'b0, 1'b1, C_LW, 1'b0, E_ZERO));
        s.push_back(mk(1'b1, 1'b0, C_LW, 1'b0, E_FETCH_WAIT));
        s.push_back(mk(1'b1, 1'b0, C_LW, 1'b0, E_FETCH_WAIT));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge iclk);
            got = outs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset cyc%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_lw();
        cyc_t s[$];
        logic [16:0] got, e;
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_FETCH_RDY));
        s.push_back(mk(1'b1, 1'b1, C_LW, 1'b0, E_DECODE));
        s.push_back(mk(1'b1, 1'b1, C_SW, 1'b0, E_MEMADR));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_MEMRD));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_MEMWB));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_FETCH_WAIT));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge iclk);
            got = outs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL lw cyc%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_rtype();
        cyc_t s[$];
        logic [16:0] got, e;
        s.push_back(mk(1'b1, 1'b1, C_R, 1'b1, E_FETCH_RDY));
        s.push_back(mk(1'b1, 1'b1, C_R, 1'b0, E_DECODE));
        s.push_back(mk(1'b1, 1'b0, C_R, 1'b1, E_RTEX));
        s.push_back(mk(1'b1, 1'b0, C_R, 1'b1, E_RTWB));
        s.push_back(mk(1'b1, 1'b0, C_R, 1'b1, E_FETCH_WAIT));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge iclk);
            got = outs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rtype cyc%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_sw_stall();
        cyc_t s[$];
        logic [16:0] got, e;
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_FETCH_RDY));
        s.push_back(mk(1'b1, 1'b1, C_SW, 1'b0, E_DECODE));
        s.push_back(mk(1'b1, 1'b1, C_LW, 1'b0, E_MEMADR));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_MEMWR));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_MEMWR));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_MEMWR));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_MEMWR));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_FETCH_WAIT));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge iclk);
            got = outs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL sw_stall cyc%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_beq_j();
        cyc_t s[$];
        logic [16:0] got, e;
        s.push_back(mk(1'b1, 1'b1, C_R,   1'b1, E_FETCH_RDY));
        s.push_back(mk(1'b1, 1'b1, C_BEQ, 1'b0, E_DECODE));
        s.push_back(mk(1'b1, 1'b0, C_R,   1'b1, E_BEQ));
        s.push_back(mk(1'b1, 1'b1, C_R,   1'b1, E_FETCH_RDY));
        s.push_back(mk(1'b1, 1'b1, C_J,   1'b0, E_DECODE));
        s.push_back(mk(1'b1, 1'b0, C_R,   1'b1, E_JEX));
        s.push_back(mk(1'b1, 1'b0, C_R,   1'b1, E_FETCH_WAIT));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge iclk);
            got = outs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL beq_j cyc%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_illegal();
        cyc_t s[$];
        logic [16:0] got, e;
        s.push_back(mk(1'b1, 1'b1, C_R,    1'b1, E_FETCH_RDY));
        s.push_back(mk(1'b1, 1'b1, C_BAD,  1'b0, E_DEC_ILL));
        s.push_back(mk(1'b1, 1'b0, C_BAD,  1'b0, E_FETCH_WAIT));
        s.push_back(mk(1'b1, 1'b1, C_R,    1'b1, E_FETCH_RDY));
`ifdef MC_MAIN_CTRL_ADDI_EN
        s.push_back(mk(1'b1, 1'b1, C_ADDI, 1'b0, E_DECODE));
        s.push_back(mk(1'b1, 1'b0, C_R,    1'b1, E_MEMADR));
        s.push_back(mk(1'b1, 1'b0, C_R,    1'b1, E_ADDIWB));
`else
        s.push_back(mk(1'b1, 1'b1, C_ADDI, 1'b0, E_DEC_ILL));
`endif
        s.push_back(mk(1'b1, 1'b0, C_R,    1'b1, E_FETCH_WAIT));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge iclk);
            got = outs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL illegal cyc%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t s[$];
        logic [16:0] got, e;
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_FETCH_WAIT));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_FETCH_RDY));
        s.push_back(mk(1'b1, 1'b1, C_LW, 1'b0, E_DECODE));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_MEMADR));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_MEMRD));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_MEMRD));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_MEMWB));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_FETCH_RDY));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b0, E_DECODE));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_RTEX));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_RTWB));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_FETCH_WAIT));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge iclk);
            got = outs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc_t s[$];
        logic [16:0] got, e;
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_FETCH_RDY));
        s.push_back(mk(1'b1, 1'b1, C_LW, 1'b0, E_DECODE));
        s.push_back(mk(1'b1, 1'b1, C_R,  1'b1, E_MEMADR));
        s.push_back(mk(1'b0, 1'b1, C_R,  1'b1, E_ZERO));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_FETCH_WAIT));
        s.push_back(mk(1'b1, 1'b0, C_R,  1'b1, E_FETCH_WAIT));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge iclk);
            got = outs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid cyc%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        irst_n           = 1'b0;
        bus_if.iMemReady = 1'b1;
        bus_if.iopcode   = C_LW;
        test_reset();
        test_lw();
        test_rtype();
        test_sw_stall();
        test_beq_j();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
